// File: rtl/fft_pkg.sv
// Shared constants, types and fixed-point helpers for the 64-point FFT datapath.
// Both helpers work on 64-bit signed values so that callers of any width can use them.
package fft_pkg;

  localparam int FFT_N     = 64;
  localparam int TW_ADDR_W = 5;
  localparam int SAMPLE_W  = 16;
  localparam int TW_W      = 16;
  localparam int TW_QTR    = FFT_N / 4;

  typedef struct packed {
    logic signed [SAMPLE_W-1:0] re;
    logic signed [SAMPLE_W-1:0] im;
  } cplx_t;

  typedef struct packed {
    logic signed [TW_W-1:0] re;
    logic signed [TW_W-1:0] im;
  } tw_t;

  // Round half up, then arithmetic shift right by sh (sh >= 1).
  function automatic logic signed [63:0] round_shr(input logic signed [63:0] v, input int sh);
    logic signed [63:0] half;
    half = 64'sd1 <<< (sh - 1);
    return (v + half) >>> sh;
  endfunction

  function automatic logic signed [63:0] sat_to_width(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/fft_cmul_pipe.sv
// Two-stage complex multiply t = W*b: products in the first stage, combine and round
// in the second. A bypass flag passes b through unrounded for the exact k = 0 case.
module fft_cmul_pipe
  import fft_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int TW_WIDTH = 16
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_en,
  input  logic                      i_bypass,
  input  logic signed [WIDTH-1:0]   i_b_re,
  input  logic signed [WIDTH-1:0]   i_b_im,
  input  logic signed [TW_WIDTH-1:0] i_w_re,
  input  logic signed [TW_WIDTH-1:0] i_w_im,
  output logic signed [WIDTH:0]     o_t_re,
  output logic signed [WIDTH:0]     o_t_im
);

  localparam int PW = WIDTH + TW_WIDTH;

  logic signed [PW-1:0]    r_p_rr;
  logic signed [PW-1:0]    r_p_ii;
  logic signed [PW-1:0]    r_p_ri;
  logic signed [PW-1:0]    r_p_ir;
  logic                    r_byp;
  logic signed [WIDTH-1:0] r_b_re;
  logic signed [WIDTH-1:0] r_b_im;
  logic signed [PW:0]      w_d_re;
  logic signed [PW:0]      w_d_im;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_p_rr <= '0;
      r_p_ii <= '0;
      r_p_ri <= '0;
      r_p_ir <= '0;
      r_byp  <= 1'b0;
      r_b_re <= '0;
      r_b_im <= '0;
    end else if (i_en) begin
      r_p_rr <= PW'(i_b_re) * PW'(i_w_re);
      r_p_ii <= PW'(i_b_im) * PW'(i_w_im);
      r_p_ri <= PW'(i_b_re) * PW'(i_w_im);
      r_p_ir <= PW'(i_b_im) * PW'(i_w_re);
      r_byp  <= i_bypass;
      r_b_re <= i_b_re;
      r_b_im <= i_b_im;
    end
  end

  always_comb begin
    w_d_re = (PW+1)'(r_p_rr) - (PW+1)'(r_p_ii);
    w_d_im = (PW+1)'(r_p_ri) + (PW+1)'(r_p_ir);
  end

  // With |W| <= 1 the rounded product fits in WIDTH+1 bits, so truncation is safe.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_t_re <= '0;
      o_t_im <= '0;
    end else if (i_en) begin
      o_t_re <= r_byp ? (WIDTH+1)'(r_b_re) : (WIDTH+1)'(round_shr(64'(w_d_re), TW_WIDTH - 1));
      o_t_im <= r_byp ? (WIDTH+1)'(r_b_im) : (WIDTH+1)'(round_shr(64'(w_d_im), TW_WIDTH - 1));
    end
  end

endmodule

// File: rtl/twiddle_rom_64.sv
// Combinational twiddle table: W^k = cos(2*pi*k/64) - j*sin(2*pi*k/64), Q1.15, k = 0..31.
// Built from one quarter-wave magnitude table; the k = 0 real part clamps to +32767.
module twiddle_rom_64
  import fft_pkg::*;
(
  input  logic [TW_ADDR_W-1:0] i_addr,
  output tw_t                  o_w
);

  function automatic logic [TW_W:0] cos_mag(input logic [TW_ADDR_W-1:0] i);
    case (i)
      5'd0:    return 17'd32768;
      5'd1:    return 17'd32610;
      5'd2:    return 17'd32138;
      5'd3:    return 17'd31357;
      5'd4:    return 17'd30274;
      5'd5:    return 17'd28899;
      5'd6:    return 17'd27246;
      5'd7:    return 17'd25330;
      5'd8:    return 17'd23170;
      5'd9:    return 17'd20788;
      5'd10:   return 17'd18205;
      5'd11:   return 17'd15447;
      5'd12:   return 17'd12540;
      5'd13:   return 17'd9512;
      5'd14:   return 17'd6393;
      5'd15:   return 17'd3212;
      default: return 17'd0;
    endcase
  endfunction

  localparam logic [TW_ADDR_W-1:0] QTR = TW_ADDR_W'(TW_QTR);

  logic [TW_ADDR_W-1:0]   w_im_idx;
  logic signed [TW_W+1:0] w_re_ext;

  // sin(k*pi/32) equals the cosine magnitude at |k - 16|.
  always_comb begin
    w_im_idx = (i_addr >= QTR) ? (i_addr - QTR) : (QTR - i_addr);
    if (i_addr <= QTR) begin
      w_re_ext = $signed({1'b0, cos_mag(i_addr)});
    end else begin
      w_re_ext = -$signed({1'b0, cos_mag(5'd0 - i_addr)});
    end
    o_w.re = (w_re_ext > 18'sd32767) ? 16'sd32767 : w_re_ext[TW_W-1:0];
    o_w.im = TW_W'(-$signed({1'b0, cos_mag(w_im_idx)}));
  end

endmodule

// File: rtl/fft_bfly_r2.sv
// Four-stage radix-2 DIT butterfly: x = a + W^k*b, y = a - W^k*b, optional 1/2 scaling,
// sticky saturation flag. Valid/ready: a beat moves on in_valid&in_ready and on
// out_valid&out_ready; the whole pipe advances only when en = out_ready | ~out_valid.
module fft_bfly_r2
  import fft_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int TW_WIDTH = 16,
  parameter int SCALE    = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] a_re,
  input  logic signed [WIDTH-1:0] a_im,
  input  logic signed [WIDTH-1:0] b_re,
  input  logic signed [WIDTH-1:0] b_im,
  input  logic [TW_ADDR_W-1:0]    tw_addr,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] x_re,
  output logic signed [WIDTH-1:0] x_im,
  output logic signed [WIDTH-1:0] y_re,
  output logic signed [WIDTH-1:0] y_im,
  output logic                    out_last,
  output logic                    sat
);

  logic w_en;
  tw_t  w_rom;

  logic                    r_s1_valid;
  logic                    r_s1_last;
  logic                    r_s1_byp;
  logic signed [WIDTH-1:0] r_s1_a_re;
  logic signed [WIDTH-1:0] r_s1_a_im;
  logic signed [WIDTH-1:0] r_s1_b_re;
  logic signed [WIDTH-1:0] r_s1_b_im;
  tw_t                     r_s1_w;

  logic                    r_s2_valid;
  logic                    r_s2_last;
  logic signed [WIDTH-1:0] r_s2_a_re;
  logic signed [WIDTH-1:0] r_s2_a_im;

  logic                    r_s3_valid;
  logic                    r_s3_last;
  logic signed [WIDTH-1:0] r_s3_a_re;
  logic signed [WIDTH-1:0] r_s3_a_im;

  logic signed [WIDTH:0]   w_t_re;
  logic signed [WIDTH:0]   w_t_im;

  logic signed [WIDTH+1:0] w_raw [4];
  logic signed [63:0]      w_scl [4];
  logic signed [WIDTH-1:0] w_clp [4];
  logic [3:0]              w_clamp;

  assign w_en     = out_ready | ~out_valid;
  assign in_ready = w_en;

  twiddle_rom_64 u_rom (
    .i_addr (tw_addr),
    .o_w    (w_rom)
  );

  // S1..S3 control and the a operand; b and W go through the multiplier pipe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_byp   <= 1'b0;
      r_s1_a_re  <= '0;
      r_s1_a_im  <= '0;
      r_s1_b_re  <= '0;
      r_s1_b_im  <= '0;
      r_s1_w     <= '0;
      r_s2_valid <= 1'b0;
      r_s2_last  <= 1'b0;
      r_s2_a_re  <= '0;
      r_s2_a_im  <= '0;
      r_s3_valid <= 1'b0;
      r_s3_last  <= 1'b0;
      r_s3_a_re  <= '0;
      r_s3_a_im  <= '0;
    end else if (w_en) begin
      r_s1_valid <= in_valid;
      r_s1_last  <= in_last;
      r_s1_byp   <= (tw_addr == '0);
      r_s1_a_re  <= a_re;
      r_s1_a_im  <= a_im;
      r_s1_b_re  <= b_re;
      r_s1_b_im  <= b_im;
      r_s1_w     <= w_rom;
      r_s2_valid <= r_s1_valid;
      r_s2_last  <= r_s1_last;
      r_s2_a_re  <= r_s1_a_re;
      r_s2_a_im  <= r_s1_a_im;
      r_s3_valid <= r_s2_valid;
      r_s3_last  <= r_s2_last;
      r_s3_a_re  <= r_s2_a_re;
      r_s3_a_im  <= r_s2_a_im;
    end
  end

  fft_cmul_pipe #(
    .WIDTH    (WIDTH),
    .TW_WIDTH (TW_WIDTH)
  ) u_cmul (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_en     (w_en),
    .i_bypass (r_s1_byp),
    .i_b_re   (r_s1_b_re),
    .i_b_im   (r_s1_b_im),
    .i_w_re   (r_s1_w.re),
    .i_w_im   (r_s1_w.im),
    .o_t_re   (w_t_re),
    .o_t_im   (w_t_im)
  );

  // Order of the four lanes: x_re, x_im, y_re, y_im.
  always_comb begin
    w_clamp  = '0;
    w_raw[0] = (WIDTH+2)'(r_s3_a_re) + (WIDTH+2)'(w_t_re);
    w_raw[1] = (WIDTH+2)'(r_s3_a_im) + (WIDTH+2)'(w_t_im);
    w_raw[2] = (WIDTH+2)'(r_s3_a_re) - (WIDTH+2)'(w_t_re);
    w_raw[3] = (WIDTH+2)'(r_s3_a_im) - (WIDTH+2)'(w_t_im);
    for (int i = 0; i < 4; i++) begin
      w_scl[i]   = (SCALE != 0) ? round_shr(64'(w_raw[i]), 1) : 64'(w_raw[i]);
      w_clp[i]   = WIDTH'(sat_to_width(w_scl[i], WIDTH));
      w_clamp[i] = (64'(w_clp[i]) != w_scl[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      x_re      <= '0;
      x_im      <= '0;
      y_re      <= '0;
      y_im      <= '0;
      sat       <= 1'b0;
    end else if (w_en) begin
      out_valid <= r_s3_valid;
      out_last  <= r_s3_last;
      x_re      <= w_clp[0];
      x_im      <= w_clp[1];
      y_re      <= w_clp[2];
      y_im      <= w_clp[3];
      if (r_s3_valid && (|w_clamp)) begin
        sat <= 1'b1;
      end
    end
  end

endmodule
